ps2_host_tx: RTL

//  PS/2 host-to-device transmitter, the send direction of the keyboard link. Sends one

---
 rtl/ps2_host_tx.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_host_tx
//  Purpose  : PS/2 host-to-device command transmitter (inhibit, RTS, 10-bit frame, ACK)
//  Revision : 1.0
// ============================================================================
module ps2_host_tx #(
    parameter int INHIBIT_CYC = 5000,
    parameter int RTS_CYC     = 500,
    parameter int TIMEOUT_CYC = 750000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int c_MAX01 = (INHIBIT_CYC > RTS_CYC) ? INHIBIT_CYC : RTS_CYC;
    localparam int c_MAX   = (c_MAX01 > TIMEOUT_CYC) ? c_MAX01 : TIMEOUT_CYC;
    localparam int c_CW    = $clog2(c_MAX) + 1;

    localparam logic [c_CW-1:0] c_INH_LAST = c_CW'(INHIBIT_CYC - 1);
    localparam logic [c_CW-1:0] c_RTS_LAST = c_CW'(RTS_CYC - 1);
    localparam logic [c_CW-1:0] c_TO_LAST  = c_CW'(TIMEOUT_CYC - 1);
    localparam logic [c_CW-1:0] c_ONE      = {{(c_CW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_RTS       = 3'd2,
        ST_SEND      = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            w_accept;
    logic            w_wdog_state;
    logic            w_timeout;

    logic            r_clk_s1, r_clk_s2, r_clk_s3;
    logic            r_data_s1, r_data_s2;
    logic            r_fall;

    logic [c_CW-1:0] r_cnt;
    logic [9:0]      r_shift;
    logic [3:0]      r_bit;
    logic            r_data_oe;

    // Lines idle high, so synchronisers reset high to avoid a false edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_s1  <= 1'b1;
            r_clk_s2  <= 1'b1;
            r_clk_s3  <= 1'b1;
            r_data_s1 <= 1'b1;
            r_data_s2 <= 1'b1;
            r_fall    <= 1'b0;
        end else begin
            r_clk_s1  <= ps2_clk_i;
            r_clk_s2  <= r_clk_s1;
            r_clk_s3  <= r_clk_s2;
            r_data_s1 <= ps2_data_i;
            r_data_s2 <= r_data_s1;
            r_fall    <= r_clk_s3 & ~r_clk_s2;
        end
    end

    assign w_wdog_state = (r_state == ST_SEND) || (r_state == ST_ACK) ||
                          (r_state == ST_WAIT_IDLE);
    assign w_timeout    = w_wdog_state && !r_fall && (r_cnt == c_TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        tx_done  = 1'b0;
        tx_err   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (tx_start) begin
                    w_accept = 1'b1;
                    w_next   = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (r_cnt == c_INH_LAST) w_next = ST_RTS;
            end
            ST_RTS: begin
                if (r_cnt == c_RTS_LAST) w_next = ST_SEND;
            end
            ST_SEND: begin
                if (r_fall) begin
                    if (r_bit == 4'd9) w_next = ST_ACK;
                end else if (w_timeout) begin
                    tx_err = 1'b1;
                    w_next = ST_IDLE;
                end
            end
            ST_ACK: begin
                if (r_fall) begin
                    if (r_data_s2) begin
                        tx_err = 1'b1;
                        w_next = ST_IDLE;
                    end else begin
                        w_next = ST_WAIT_IDLE;
                    end
                end else if (w_timeout) begin
                    tx_err = 1'b1;
                    w_next = ST_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (r_clk_s2 && r_data_s2) begin
                    tx_done = 1'b1;
                    w_next  = ST_IDLE;
                end else if (w_timeout) begin
                    tx_err = 1'b1;
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // One counter serves as phase timer (INHIBIT/RTS) and as watchdog afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if ((r_state == ST_IDLE) || (w_next != r_state) ||
                     (w_wdog_state && r_fall)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= '0;
            r_bit     <= '0;
            r_data_oe <= 1'b0;
        end else if (w_accept) begin
            r_shift   <= {1'b1, ~^tx_data, tx_data};
            r_bit     <= '0;
            r_data_oe <= 1'b0;
        end else if (r_state == ST_RTS) begin
            r_data_oe <= 1'b1;
        end else if ((r_state == ST_SEND) && r_fall) begin
            r_data_oe <= ~r_shift[0];
            r_shift   <= {1'b0, r_shift[9:1]};
            r_bit     <= r_bit + 4'd1;
        end
    end

    assign tx_busy     = (r_state != ST_IDLE);
    assign ps2_clk_oe  = (r_state == ST_INHIBIT) || (r_state == ST_RTS);
    assign ps2_data_oe = (r_state == ST_RTS) || ((r_state == ST_SEND) && r_data_oe);

endmodule
`default_nettype wire
